// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch requests under a credit
// limit, queues in-order responses in a small FIFO for decode, and discards
// stale responses after a redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);

   // QDEPTH must be a power of two (pointers wrap naturally) and at least 2.
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] QD_LIMIT = (CW+1)'(QDEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [31:0]   fifo_instr [QDEPTH];
   logic [31:0]   fifo_pc    [QDEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;

   logic [CW:0]   credit_sum;
   logic          req_valid;
   logic          req_fire;
   logic          push;
   logic          drop;
   logic          pop;
   logic [CW-1:0] out_after_resp;
   logic [CW-1:0] outstanding_next;
   logic [CW-1:0] count_next;
   logic [31:0]   redirect_aligned;

   // Credit check, handshake decode and next-state arithmetic for the counters.
   always_comb begin
      credit_sum       = {1'b0, count} + {1'b0, outstanding};
      req_valid        = rst && !redirect_valid && (credit_sum < QD_LIMIT);
      req_fire         = req_valid && imem_req_ready;
      redirect_aligned = {redirect_pc[31:2], 2'b00};
      push             = 1'b0;
      drop             = 1'b0;
      if (imem_resp_valid && !redirect_valid) begin
         if (discard == {CW{1'b0}}) begin
            push = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else begin
         push = 1'b0;
         drop = 1'b0;
      end
      // A pop in the redirect cycle is still delivered; the flush wins anyway.
      pop = (count != {CW{1'b0}}) && out_ready && !redirect_valid;
      if (imem_resp_valid) begin
         out_after_resp = outstanding - CW'(1);
      end else begin
         out_after_resp = outstanding;
      end
      if (req_fire) begin
         outstanding_next = out_after_resp + CW'(1);
      end else begin
         outstanding_next = out_after_resp;
      end
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Fetch/response PCs, FIFO pointers and in-flight bookkeeping; redirect wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         rd_ptr      <= {AW{1'b0}};
         wr_ptr      <= {AW{1'b0}};
         count       <= {CW{1'b0}};
         outstanding <= {CW{1'b0}};
         discard     <= {CW{1'b0}};
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_aligned;
         resp_pc     <= redirect_aligned;
         rd_ptr      <= {AW{1'b0}};
         wr_ptr      <= {AW{1'b0}};
         count       <= {CW{1'b0}};
         // Every word still in flight after this cycle's response is stale.
         outstanding <= out_after_resp;
         discard     <= out_after_resp;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (push) begin
            resp_pc <= resp_pc + 32'd4;
            wr_ptr  <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (drop) begin
            discard <= discard - CW'(1);
         end
         count       <= count_next;
         outstanding <= outstanding_next;
      end
   end

   // Queue storage: capture each accepted response together with its address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QDEPTH; i++) begin
            fifo_instr[i] <= 32'h0000_0000;
            fifo_pc[i]    <= 32'h0000_0000;
         end
      end else if (push) begin
         fifo_instr[wr_ptr] <= imem_resp_data;
         fifo_pc[wr_ptr]    <= resp_pc;
      end
   end

   assign imem_req_valid = req_valid;
   assign imem_req_addr  = fetch_pc;
   assign out_valid      = (count != {CW{1'b0}});
   assign out_instr      = fifo_instr[rd_ptr];
   assign out_pc         = fifo_pc[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural latency-L instruction memory.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0000_0000;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0000_0000;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   int total = 0;
   int bad = 0;
   int mem_lat = 1;
   int cyc = 0;
   int req_cnt = 0;
   int pend_due[$];
   logic [31:0] pend_data[$];
   logic mem_fire;

   fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   // Memory model: a request accepted in cycle t answers in cycle t+mem_lat.
   always @(posedge clk) begin
      mem_fire = rst && imem_req_valid && imem_req_ready;
      if (!rst) begin
         pend_due.delete();
         pend_data.delete();
         req_cnt = 0;
      end else if (mem_fire) begin
         pend_due.push_back(cyc + mem_lat);
         pend_data.push_back(imem_req_addr ^ 32'hC0DE_0000);
         req_cnt = req_cnt + 1;
      end
      cyc = cyc + 1;
      #1;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = pend_data[0];
         void'(pend_due.pop_front());
         void'(pend_data.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0000_0000;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Assert reset (checking the asynchronous effect), hold it, then release.
   task automatic do_reset(input int lat);
      tick();
      rst = 1'b0;
      redirect_valid = 1'b0;
      mem_lat = lat;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
      tick();
      tick();
      rst = 1'b1;
      #1;
   endtask

   initial begin
      // Streaming with L=1, then redirect collisions and address wrap.
      imem_req_ready = 1'b1;
      out_ready = 1'b1;
      do_reset(1);
      chk("c0_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("c0_addr", imem_req_addr, 32'h0000_0000);
      tick();
      chk("c1_addr", imem_req_addr, 32'h0000_0004);
      chk("c1_no_bypass", {31'd0, out_valid}, 32'd0);
      tick();
      chk("c2_addr", imem_req_addr, 32'h0000_0008);
      chk("c2_out_valid", {31'd0, out_valid}, 32'd1);
      chk("c2_out_pc", out_pc, 32'h0000_0000);
      chk("c2_out_instr", out_instr, 32'hC0DE_0000);
      tick();
      chk("c3_out_pc", out_pc, 32'h0000_0004);
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      #1;
      chk("rd_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("rd_deliver_pc", out_pc, 32'h0000_0008);
      chk("rd_deliver_v", {31'd0, out_valid}, 32'd1);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("rd_flushed", {31'd0, out_valid}, 32'd0);
      chk("rd_new_addr", imem_req_addr, 32'h0000_0200);
      chk("rd_new_valid", {31'd0, imem_req_valid}, 32'd1);
      tick();
      chk("rd_c6_empty", {31'd0, out_valid}, 32'd0);
      tick();
      chk("rd_first_pc", out_pc, 32'h0000_0200);
      chk("rd_first_instr", out_instr, 32'hC0DE_0200);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("wrap_align", imem_req_addr, 32'hFFFF_FFFC);
      chk("wrap_empty", {31'd0, out_valid}, 32'd0);
      tick();
      chk("wrap_next", imem_req_addr, 32'h0000_0000);
      tick();
      chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
      chk("wrap_out_instr", out_instr, 32'h3F21_FFFC);
      chk("wrap_addr4", imem_req_addr, 32'h0000_0004);
      tick();
      chk("wrap_out_pc0", out_pc, 32'h0000_0000);

      // Decode stalled: credits stop requests at QDEPTH.
      out_ready = 1'b0;
      do_reset(1);
      for (int i = 0; i < 6; i++) tick();
      chk("full_req_cnt", 32'(req_cnt), 32'd4);
      chk("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("full_out_valid", {31'd0, out_valid}, 32'd1);
      chk("full_out_pc", out_pc, 32'h0000_0000);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      chk("full_pop_req", {31'd0, imem_req_valid}, 32'd1);
      chk("full_pop_addr", imem_req_addr, 32'h0000_0010);
      chk("full_pop_pc", out_pc, 32'h0000_0004);

      // Memory stalls the second request for three cycles.
      out_ready = 1'b1;
      imem_req_ready = 1'b1;
      do_reset(1);
      chk("stall_c0_addr", imem_req_addr, 32'h0000_0000);
      tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_addr", imem_req_addr, 32'h0000_0004);
         chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
         tick();
      end
      imem_req_ready = 1'b1;
      #1;
      chk("stall_hold_addr", imem_req_addr, 32'h0000_0004);
      chk("stall_cnt1", 32'(req_cnt), 32'd1);
      tick();
      chk("stall_next_addr", imem_req_addr, 32'h0000_0008);
      chk("stall_cnt2", 32'(req_cnt), 32'd2);

      // L=3 with two stale words in flight at the redirect.
      do_reset(3);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      chk("l3_rd_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("l3_addr", imem_req_addr, 32'h0000_0100);
      chk("l3_valid", {31'd0, imem_req_valid}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("l3_no_stale", {31'd0, out_valid}, 32'd0);
         tick();
      end
      chk("l3_out_valid", {31'd0, out_valid}, 32'd1);
      chk("l3_out_pc", out_pc, 32'h0000_0100);
      chk("l3_out_instr", out_instr, 32'hC0DE_0100);
      tick();
      chk("l3_out_pc2", out_pc, 32'h0000_0104);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
